// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: per-line walk of the sprite attribute table, emitting up to
// MAX_PER_LINE Y-matching sprites in index order with their row offsets.
module sprite_line_scanner #(
    parameter int NUM_SPRITES  = 512,
    parameter int MAX_PER_LINE = 16,
    parameter int Y_WIDTH      = 12,
    parameter int COORD_WIDTH  = 16,
    parameter int DY_WIDTH     = 10,
    localparam int IW = $clog2(NUM_SPRITES),
    localparam int CW = $clog2(MAX_PER_LINE + 1)
) (
    input  logic                   clk_draw,
    input  logic                   rst,
    input  logic                   line,
    input  logic [Y_WIDTH-1:0]     next_sy,
    output logic [IW-1:0]          attr_index,
    input  logic [COORD_WIDTH-1:0] attr_screen_y,
    input  logic [COORD_WIDTH-6:0] attr_height,
    input  logic                   attr_tile_size,
    output logic                   match_valid,
    output logic [CW-1:0]          match_slot,
    output logic [IW-1:0]          match_index,
    output logic [DY_WIDTH-1:0]    match_dy,
    output logic [CW-1:0]          match_count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t state, next_state;
    logic [COORD_WIDTH-1:0] sy, height;
    logic [COORD_WIDTH:0]   last_y;
    logic [DY_WIDTH-1:0]    dy;
    logic [IW-1:0]          cmp_index;
    logic                   cmp_valid, last_idx, hit, full;
    always_comb begin
        last_idx   = attr_index == IW'(NUM_SPRITES - 1);
        next_state = line ? SCAN :
                     (state == SCAN && last_idx) ? DRAIN :
                     (state == DRAIN) ? IDLE : state;
        height     = attr_tile_size ? {attr_height, 5'b0} : {1'b0, attr_height, 4'b0};
        // one extra bit so a sprite near the top of the coordinate space cannot wrap
        last_y     = {1'b0, attr_screen_y} + {1'b0, height};
        hit        = cmp_valid && sy >= attr_screen_y && {1'b0, sy} < last_y;
        dy         = DY_WIDTH'(sy - attr_screen_y);
        full       = match_count == CW'(MAX_PER_LINE);
    end
    always_ff @(posedge clk_draw or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_ff @(posedge clk_draw or posedge rst) begin
        if (rst) begin
            sy          <= '0;
            attr_index  <= '0;
            cmp_valid   <= 1'b0;
            cmp_index   <= '0;
            match_valid <= 1'b0;
            match_slot  <= '0;
            match_index <= '0;
            match_dy    <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (line) begin
            // restart drops any in-flight comparison of the previous scan
            sy          <= COORD_WIDTH'(next_sy);
            attr_index  <= '0;
            cmp_valid   <= 1'b0;
            match_valid <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else begin
            attr_index  <= (state == SCAN && !last_idx) ? attr_index + 1'b1 : attr_index;
            cmp_valid   <= state == SCAN;
            cmp_index   <= attr_index;
            match_valid <= hit && !full;
            overflow    <= overflow | (hit && full);
            busy        <= next_state != IDLE;
            done        <= cmp_valid && cmp_index == IW'(NUM_SPRITES - 1);
            if (hit && !full) begin
                match_slot  <= match_count;
                match_index <= cmp_index;
                match_dy    <= dy;
                match_count <= match_count + 1'b1;
            end
        end
    end
endmodule

// File: doc/sprite_line_scanner.md
# sprite_line_scanner

Parametrised per-line sprite Y scanner for the draw pipeline. On each `line` pulse it walks the sprite attribute table once through a registered-read port, tests every entry against the latched next scanline, and emits an ordered list of up to `MAX_PER_LINE` matching sprites, with the row offset of each, to the line fetcher. It adds capacity limiting, overflow detection, a done strobe and restart-on-`line`, none of which the single-counter matcher had.

## Interface
- `NUM_SPRITES`, 512: attribute table entries scanned per line; must be ≥ 2.
- `MAX_PER_LINE`, 16: capacity of the per-line match list; must be ≥ 1.
- `Y_WIDTH`, 12: width of `next_sy`.
- `COORD_WIDTH`, 16: width of sprite `screen_y`; the height field is `COORD_WIDTH-5` bits.
- `DY_WIDTH`, 10: width of the emitted row offset.
- Index width `IW = $clog2(NUM_SPRITES)` and count width `CW = $clog2(MAX_PER_LINE+1)` are derived, not overridable.

Ports:
- `clk_draw`  in  1  draw clock; sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `line`  in  1  one-cycle start pulse; restarts the scan from any state.
- `next_sy`  in  Y_WIDTH  scanline to match; sampled only on `line`.
- `attr_index`  out  IW  attribute read address.
- `attr_screen_y`  in  COORD_WIDTH  sprite top Y; valid the cycle after its `attr_index`.
- `attr_height`  in  COORD_WIDTH-5  sprite height in tiles.
- `attr_tile_size`  in  1  1 means 32-line tiles, 0 means 16-line tiles.
- `match_valid`  out  1  one-cycle strobe; a match entry is present.
- `match_slot`  out  CW  list slot, 0..MAX_PER_LINE-1.
- `match_index`  out  IW  sprite index of the match.
- `match_dy`  out  DY_WIDTH  low DY_WIDTH bits of (sy − screen_y).
- `match_count`  out  CW  number of entries accepted so far this line.
- `overflow`  out  1  at least one match was dropped because the list was full.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle strobe marking the final result of the scan.

## Operation
- States: IDLE, SCAN, DRAIN.
  - `line` in any state: latch `next_sy` zero-extended to COORD_WIDTH as `sy`, set `attr_index` to 0, clear `match_count` and `overflow`, go to SCAN.
  - SCAN: `attr_index` increments by 1 per cycle. After issuing `NUM_SPRITES-1`, the state goes to DRAIN.
  - DRAIN: lasts one cycle while the last attribute is compared, then returns to IDLE.
- `attr_index` holds its value in IDLE and does not wrap.
- A registered `cmp_valid`/`cmp_index` pipeline tracks which index the returning attribute data belongs to.
- Height in lines is `attr_height << 5` when `attr_tile_size` is 1, else `attr_height << 4`, computed at COORD_WIDTH width.
- `last_y = attr_screen_y + height`, computed at COORD_WIDTH+1 bits. The add never wraps.
- A sprite matches when `sy >= attr_screen_y` and `sy < last_y`, both unsigned. Height 0 never matches.
- Accepted match (match while `match_count < MAX_PER_LINE`):
  - `match_valid` = 1.
  - `match_slot` = `match_count`.
  - `match_index` = `cmp_index`.
  - `match_dy` = (sy − attr_screen_y)[DY_WIDTH-1:0].
  - `match_count` increments.
- Match while `match_count == MAX_PER_LINE`: no strobe, `overflow` latches to 1, and scanning continues.
- Entries are emitted in ascending sprite index order. Slots are dense and start at 0.
- `overflow` and `match_count` hold until the next `line` or `rst`.
- `busy` = 1 in SCAN and DRAIN.
- `done` pulses in the cycle the result for index `NUM_SPRITES-1` is presented, coincident with its `match_valid` if it matches.

## Timing
- Reset values: `attr_index` = 0, `match_valid` = 0, `match_slot` = 0, `match_index` = 0, `match_dy` = 0, `match_count` = 0, `overflow` = 0, `busy` = 0, `done` = 0; state IDLE.
- `line` sampled at edge E0: after E0, `attr_index` = 0 and `busy` = 1.
- After edge E(i): `attr_index` = i, for i = 0..N-1.
- Attribute data for index i is valid between E(i+1) and E(i+2).
- The result for index i is registered at E(i+2). Total scan latency is `NUM_SPRITES+2` edges from `line`.
- `done` is high for the single cycle after E(N+1). `busy` falls after E(N+1).
- `match_count` updates in the same cycle its `match_valid` is shown.
- Restart: `line` mid-scan cancels in-flight comparisons; no strobe from the old scan appears after the restart edge.
- `line` in the same cycle as the final result: the restart wins, and `done` and `match_valid` are suppressed.
- `rst` mid-scan returns all outputs to their reset values immediately.
- Outputs are driven from registers only.

## Test plan
Bench parameters: NUM_SPRITES = 8, MAX_PER_LINE = 2, COORD_WIDTH = 16.
- **Boundary:** sprite 3 has y = 100, height = 1, tile_size = 0; `line` with sy = 115 → exactly one strobe 5 cycles after `line` (slot 0, index 3, dy 15); sy = 116 → no strobe; sy = 99 → no strobe.
- **Tile size:** sprite 0 has y = 10, height = 1, tile_size = 1; sy = 41 → match with dy = 31; sy = 42 → no match.
- **Overflow:** sprites 1, 4 and 6 all cover sy = 50 → strobes for index 1 (slot 0) and index 4 (slot 1); `overflow` rises at the index-6 result; `match_count` = 2; `done` occurs 9 cycles after `line`.
- **No wrap:** sprite 7 has y = 0xFFF0, height = 1; sy = 5 → no match; `done` coincides with the index-7 result; `overflow` = 0.
- **Restart:** second `line` (sy = 200) 4 cycles into a scan at sy = 50 → no strobes from the first scan after the restart edge; `match_count` restarts at 0; one `done` only, 9 cycles after the second `line`.
- **Reset:** assert `rst` mid-scan → all outputs return to reset values within the same cycle; `busy` = 0; the next `line` scans normally.
